// File: rtl/sram_pkg.sv
// Shared types and constants for the sram_responder SRAM device model.
package sram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrWait,
        StDrive
    } sram_state_e;

    localparam int unsigned DefReadLat  = 2;
    localparam int unsigned DefWriteLat = 2;

    localparam logic [1:0]  LaneNone   = 2'b00;
    localparam logic [15:0] LaneMaskLo = 16'h00ff;
    localparam logic [15:0] LaneMaskHi = 16'hff00;

    // lanes[1] enables the upper byte, lanes[0] the lower byte (active-high).
    function automatic logic [15:0] lane_mask(input logic [1:0] lanes);
        return (lanes[1] ? LaneMaskHi : 16'h0000) | (lanes[0] ? LaneMaskLo : 16'h0000);
    endfunction

endpackage

// File: rtl/sram_array.sv
// DEPTH x 16 storage with a byte-enabled write port and a registered read port; never reset.
module sram_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [1:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [15:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [15:0]      rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && be[0]) begin
            mem[waddr][7:0] <= wdata[7:0];
        end
        if (we && be[1]) begin
            mem[waddr][15:8] <= wdata[15:8];
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sram_responder.sv
// Cycle-accurate SRAM device model: decodes the controller strobes, applies read/write
// latencies, honours byte lanes and drives DQ only while returning read data.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned READ_LAT  = DefReadLat,
    parameter int unsigned WRITE_LAT = DefWriteLat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    output logic              busy,
    output logic              rd_valid,
    output logic              protocol_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned MaxLat = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    sram_state_e       state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dq_q;
    logic [1:0]        lanes_q;
    logic              oe_n_q;

    logic              rd_cmd_held;
    logic              wr_cmd_held;
    logic              commit;
    logic [IDX_W-1:0]  raddr;
    logic [15:0]       rdata;

    always_comb begin
        rd_cmd_held = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && (SRAM_ADDR == addr_q);
        wr_cmd_held = !SRAM_CE_N && !SRAM_WE_N && (SRAM_OE_N == oe_n_q) &&
                      ({SRAM_UB_N, SRAM_LB_N} == ~lanes_q) && (SRAM_ADDR == addr_q);
    end

    assign commit = (state_q == StWrWait) && (cnt_q == CntW'(WRITE_LAT));
    // In IDLE the array looks up the incoming address so READ_LAT=1 still has data in time.
    assign raddr  = (state_q == StIdle) ? SRAM_ADDR[IDX_W-1:0] : addr_q[IDX_W-1:0];

    sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (commit),
        .be    (lanes_q),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dq_q         <= '0;
            lanes_q      <= LaneNone;
            oe_n_q       <= 1'b1;
            busy         <= 1'b0;
            rd_valid     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!SRAM_CE_N && (!SRAM_WE_N || !SRAM_OE_N)) begin
                        addr_q  <= SRAM_ADDR;
                        lanes_q <= ~{SRAM_UB_N, SRAM_LB_N};
                        oe_n_q  <= SRAM_OE_N;
                        cnt_q   <= CntW'(1);
                        busy    <= 1'b1;
                        // WE wins over OE: a combined strobe is a write.
                        if (!SRAM_WE_N) begin
                            wdata_q <= SRAM_DQ;
                            state_q <= StWrWait;
                        end else begin
                            state_q <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    if (!rd_cmd_held) begin
                        protocol_err <= 1'b1;
                        busy         <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= StIdle;
                    end else if (cnt_q == CntW'(READ_LAT)) begin
                        dq_q     <= rdata & lane_mask(lanes_q);
                        busy     <= 1'b0;
                        rd_valid <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StDrive;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWrWait: begin
                    if (!wr_cmd_held) begin
                        protocol_err <= 1'b1;
                    end
                    if (commit) begin
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDrive: begin
                    if (!rd_cmd_held) begin
                        rd_valid <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
            endcase
        end
    end

    assign SRAM_DQ = rd_valid ? dq_q : {DATA_W{1'bz}};

endmodule

// File: doc/sram_responder.md
# sram_responder

Cycle-accurate, synthesizable SRAM device model: the responder end of the SRAM pin interface driven by `SRAM_Controller`. It decodes the active-low chip strobes and honours UB/LB byte lanes. It completes reads and writes after parameterised latencies, and drives `SRAM_DQ` only while returning read data. It replaces the zero-latency `SRAM` model in the ARM SRAM datapath, so the controller's `ready` stall path is exercised.

## Interface
- `ADDR_W`, 17: address width; matches controller `SRAM_ADDR`.
- `DATA_W`, 16: data width; must be 16 (UB = [15:8], LB = [7:0]).
- `DEPTH`, 1024: words implemented; address used modulo `DEPTH` (power of two).
- `READ_LAT`, 2: cycles from read command sample to data driven; ≥1.
- `WRITE_LAT`, 2: cycles from write command sample to array commit; ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `SRAM_ADDR`  in  ADDR_W  word address.
- `SRAM_DQ`  inout  DATA_W  bidirectional data; hi-Z unless in DRIVE.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N`  in  1 each  active-low strobes.
- `busy`  out  1  high in RD_WAIT / WR_WAIT.
- `rd_valid`  out  1  high while DQ is driven (DRIVE).
- `protocol_err`  out  1  sticky; set on any command violation, cleared only by reset.

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT, DRIVE.
- In IDLE, sample on each edge with `CE_N`=0:
  - `WE_N`=0 → WR_WAIT. Latch addr, DQ and lanes.
  - Else `OE_N`=0 → RD_WAIT. Latch addr.
  - Else stay in IDLE.
- `WE_N`=0 together with `OE_N`=0 is treated as a write. DQ is never driven in that case.
- Any access with `UB_N`=`LB_N`=1 is accepted but writes nothing and reads as 0.
- WR_WAIT:
  - Counter runs WRITE_LAT cycles.
  - On expiry, commit the latched data to the enabled lanes only, then go to IDLE.
  - Strobe or address changes during the wait set `protocol_err`; the write still commits with the latched values.
- RD_WAIT:
  - Counter runs READ_LAT cycles.
  - If `CE_N`, `OE_N`, `WE_N` or `SRAM_ADDR` deviates from the sampled command, set `protocol_err`, abort, and go to IDLE with DQ undriven.
  - On expiry, register the array word (disabled lanes forced to 0) and go to DRIVE.
- DRIVE:
  - Hold the data on DQ while `CE_N`=0, `OE_N`=0, `WE_N`=1 and the address equals the latched address.
  - Otherwise go to IDLE at the next edge. A new command is accepted from IDLE, not directly from DRIVE.
- Address wrap: words are indexed by `addr % DEPTH`, so addr `DEPTH` aliases addr 0.
- Reset at any time forces IDLE, counter 0, DQ hi-Z and all outputs 0. Array contents are not reset and are retained across reset; a write in flight at reset is discarded.

## Timing
- Reset values: `busy`=0, `rd_valid`=0, `protocol_err`=0, DQ hi-Z.
- Read sampled at edge E0 → `busy` high after E0 → DQ valid and `rd_valid`=1 after edge E0+READ_LAT.
- Write sampled at E0 → array updated at E0+WRITE_LAT. A read sampled at or after that edge returns the new data.
- The DQ output enable is registered, so there is no combinational path from the strobes to the DQ drive.
- Minimum back-to-back rate:
  - Reads: READ_LAT+2 cycles.
  - Writes: WRITE_LAT+1 cycles.

## Structure
- `sram_pkg`: FSM state enum, lane-mask helper constants, default latency constants.
- Sub-module `sram_array`: DEPTH×16 storage, one write port with 2-bit byte enable, one registered read port. Not reset.
- `sram_responder` holds the FSM, latency counter, command latch, error logic and tristate driver.

## Test plan
- Reset, then write 0xBEEF to addr 5 with both lanes, then read addr 5 → `rd_valid` after edge E0+2, DQ=0xBEEF, `busy` high for 2 cycles.
- Write 0x1234 to addr 7, then write 0xAB00 to addr 7 with `UB_N`=0, `LB_N`=1, then read addr 7 → 0xAB34. Read with only LB enabled → 0x0034.
- Write 0x5555 to addr 1024 (DEPTH=1024), then read addr 0 → 0x5555.
- Issue a read, then change `SRAM_ADDR` during RD_WAIT → `protocol_err`=1, `rd_valid` never asserts, DQ stays hi-Z, FSM back in IDLE.
- Assert `WE_N`=0 and `OE_N`=0 together with data 0x0F0F at addr 3 → treated as a write, DQ not driven; a later read of addr 3 returns 0x0F0F.
- Pull `rst` low mid-WR_WAIT of 0xFFFF to addr 9 (addr 9 previously held 0x0001) → outputs 0 and DQ hi-Z immediately; a read after reset returns 0x0001.
